decode_stage: RTL

Registered, flow-controlled RV32I instruction decode stage for the pipelined core. It sits between fetch and execute. Each instruction/PC pair is accepted on a valid/ready handshake and decoded into register addresses, a sign-extended immediate and control signals. The result is presented one cycle later through a 2-entry skid buffer, so backpressure never drops or duplicates an instruction. Beyond plain field decode, it adds illegal-instruction detection, pipeline flush, and optional RV32M decode.

---
 rtl/decode_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes each accepted instruction and holds it in a 2-entry skid buffer (M, S).
// Build option: define DECODE_RV32M_EN to accept RV32M (funct7=0000001) ops on the OP opcode.
module decode_stage #(
   parameter int PC_W  = 32,
   parameter int IMM_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [PC_W-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PC_W-1:0]  out_pc,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic [IMM_W-1:0] imm,
   output logic [2:0]       funct3,
   output logic [3:0]       alu_op,
   output logic             mul_op,
   output logic             alu_src_b,
   output logic             wreg,
   output logic [1:0]       wreg_src,
   output logic             pc_src,
   output logic             jalr,
   output logic             btype,
   output logic             store,
   output logic             load,
   output logic             illegal
);
   localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111,
                          OPC_JALR = 7'b1100111, OPC_BR = 7'b1100011, OPC_LOAD = 7'b0000011,
                          OPC_STORE = 7'b0100011, OPC_OPIMM = 7'b0010011, OPC_OP = 7'b0110011;

   typedef struct packed {
      logic [PC_W-1:0]  pc;
      logic [4:0]       rs1, rs2, rd;
      logic [IMM_W-1:0] imm;
      logic [2:0]       funct3;
      logic [3:0]       alu_op;
      logic             mul_op, alu_src_b, wreg;
      logic [1:0]       wreg_src;
      logic             pc_src, jalr, btype, store, load, illegal;
   } dec_t;

   dec_t        dec, m_q, s_q;
   logic        m_vld, s_vld, ill;
   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

   assign opc   = in_instr[6:0];
   assign f3    = in_instr[14:12];
   assign f7    = in_instr[31:25];
   assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
   assign imm_u = {in_instr[31:12], 12'b0};

   always_comb begin
      dec          = '0;
      ill          = 1'b0;
      dec.pc       = in_pc;
      dec.rs1      = in_instr[19:15];
      dec.rs2      = in_instr[24:20];
      dec.rd       = in_instr[11:7];
      dec.funct3   = f3;
      dec.wreg_src = 2'd3;
      case (opc)
         OPC_LUI:   begin dec.imm = IMM_W'($signed(imm_u)); dec.wreg = 1'b1; dec.wreg_src = 2'd0; end
         OPC_AUIPC: begin dec.imm = IMM_W'($signed(imm_u)); dec.wreg = 1'b1; dec.wreg_src = 2'd1; end
         OPC_JAL: begin
            dec.imm = IMM_W'($signed(imm_j)); dec.wreg = 1'b1; dec.wreg_src = 2'd2; dec.pc_src = 1'b1;
         end
         OPC_JALR: begin
            dec.imm = IMM_W'($signed(imm_i)); dec.wreg = 1'b1; dec.wreg_src = 2'd2;
            dec.pc_src = 1'b1; dec.jalr = 1'b1;
            ill = (f3 != 3'b000);
         end
         OPC_BR: begin
            dec.imm = IMM_W'($signed(imm_b)); dec.btype = 1'b1;
            ill = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OPC_LOAD: begin
            dec.imm = IMM_W'($signed(imm_i)); dec.wreg = 1'b1; dec.load = 1'b1; dec.alu_src_b = 1'b1;
            ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OPC_STORE: begin
            dec.imm = IMM_W'($signed(imm_s)); dec.store = 1'b1; dec.alu_src_b = 1'b1;
            ill = (f3 > 3'b010);
         end
         OPC_OPIMM: begin
            dec.imm = IMM_W'($signed(imm_i)); dec.wreg = 1'b1; dec.alu_src_b = 1'b1;
            dec.alu_op = (f3 == 3'b101) ? {in_instr[30], f3} : {1'b0, f3};
            // shift amounts live in imm[4:0]; the upper bits are funct7 and must be a known encoding
            if (f3 == 3'b001) ill = (f7 != 7'b0000000);
            if (f3 == 3'b101) ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
         end
         OPC_OP: begin
            dec.wreg   = 1'b1;
            dec.alu_op = {in_instr[30], f3};
            case (f7)
               7'b0000000: ;
               7'b0100000: ill = (f3 != 3'b000) && (f3 != 3'b101);
`ifdef DECODE_RV32M_EN
               7'b0000001: begin dec.mul_op = 1'b1; dec.alu_op = {1'b0, f3}; end
`endif
               default:    ill = 1'b1;
            endcase
         end
         default: ill = 1'b1;
      endcase
      if (in_instr[1:0] != 2'b11) ill = 1'b1;
      dec.illegal = ill;
      if (ill) begin
         dec.wreg = 1'b0; dec.store = 1'b0; dec.load = 1'b0;
         dec.pc_src = 1'b0; dec.jalr = 1'b0; dec.btype = 1'b0;
      end
   end

   // M feeds the outputs; S only fills when M is stalled, so in_ready is simply !S.valid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_vld <= 1'b0; s_vld <= 1'b0;
         m_q   <= '0;   s_q   <= '0;
      end else if (flush) begin
         m_vld <= 1'b0; s_vld <= 1'b0;
      end else if (!m_vld || out_ready) begin
         if (s_vld) begin
            m_q <= s_q; m_vld <= 1'b1; s_vld <= 1'b0;
         end else if (in_valid) begin
            m_q <= dec; m_vld <= 1'b1;
         end else begin
            m_vld <= 1'b0;
         end
      end else if (in_valid && !s_vld) begin
         s_q <= dec; s_vld <= 1'b1;
      end
   end

   assign in_ready  = !s_vld;
   assign out_valid = m_vld;
   assign out_pc    = m_q.pc;
   assign rs1       = m_q.rs1;
   assign rs2       = m_q.rs2;
   assign rd        = m_q.rd;
   assign imm       = m_q.imm;
   assign funct3    = m_q.funct3;
   assign alu_op    = m_q.alu_op;
   assign mul_op    = m_q.mul_op;
   assign alu_src_b = m_q.alu_src_b;
   assign wreg      = m_q.wreg;
   assign wreg_src  = m_q.wreg_src;
   assign pc_src    = m_q.pc_src;
   assign jalr      = m_q.jalr;
   assign btype     = m_q.btype;
   assign store     = m_q.store;
   assign load      = m_q.load;
   assign illegal   = m_q.illegal;
endmodule
